// File: rtl/alarm_timer.sv
// Alarm timer: prescaled up-counter with a settable alarm that rings until
// the downstream equation checker reports a correct, complete answer.
module alarm_timer #(
  parameter int unsigned CLKS_PER_TICK = 50000000,
  parameter int unsigned MAX_COUNT     = 99
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       SetAlarm,
  input  logic [6:0] AlarmIn,
  input  logic       correct,
  input  logic       turnOff,
  output logic [6:0] OngoingTimer,
  output logic       startEq1,
  output logic       ringing,
  output logic       tick,
  output logic       solved
);

  localparam int unsigned PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
  localparam logic [6:0]    TIMER_LAST = 7'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SOLVED
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [6:0]    alarm;
  logic [6:0]    timer_next;
  logic          tick_event;
  logic          set_ok;

  always_comb begin
    tick_event = Enable && (presc == PRESC_LAST);
    timer_next = (OngoingTimer == TIMER_LAST) ? '0 : OngoingTimer + 7'd1;
    set_ok     = SetAlarm && (AlarmIn <= TIMER_LAST);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc        <= '0;
      OngoingTimer <= '0;
    end else if (Enable) begin
      if (tick_event) begin
        presc        <= '0;
        OngoingTimer <= timer_next;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Trigger compares against the alarm value held before this edge, so a
  // coincident SetAlarm only affects later ticks.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      alarm    <= '0;
      tick     <= 1'b0;
      solved   <= 1'b0;
      startEq1 <= 1'b0;
      ringing  <= 1'b0;
    end else begin
      tick   <= tick_event;
      solved <= 1'b0;
      case (state)
        IDLE: begin
          if (set_ok) begin
            alarm <= AlarmIn;
            state <= ARMED;
          end
        end
        ARMED: begin
          if (set_ok) alarm <= AlarmIn;
          if (tick_event && (timer_next == alarm)) begin
            state    <= RINGING;
            startEq1 <= 1'b1;
            ringing  <= 1'b1;
          end
        end
        RINGING: begin
          if (correct && turnOff) begin
            state    <= SOLVED;
            solved   <= 1'b1;
            startEq1 <= 1'b0;
            ringing  <= 1'b0;
          end
        end
        SOLVED: begin
          if (tick_event) state <= ARMED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alarm_timer.md
ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 Parameter CLKS_PER_TICK, default 50000000, number of Clock cycles per timer tick (≥2).
REQ-002 Parameter MAX_COUNT, default 99, last timer value before wrap to 0 (≤127).
REQ-003 Clock  input  1  system clock; all state changes on its rising edge; one clock, reset is synchronous and active-high.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Enable  input  1  1 = prescaler and timer run; 0 = both hold their current values.
REQ-006 SetAlarm  input  1  level-sampled request to load AlarmIn as the alarm time.
REQ-007 AlarmIn  input  7  requested alarm time.
REQ-008 correct  input  1  downstream checker's answer-correct flag.
REQ-009 turnOff  input  1  downstream checker's complete flag.
REQ-010 OngoingTimer  output  7  current timer value, registered.
REQ-011 startEq1  output  1  start request to the downstream equation checker, registered.
REQ-012 ringing  output  1  alarm-active indicator, registered.
REQ-013 tick  output  1  one-cycle pulse on each timer advance, registered.
REQ-014 solved  output  1  one-cycle pulse when the alarm is dismissed, registered.

Function
REQ-015 The prescaler SHALL count 0..CLKS_PER_TICK-1 while Enable=1 and wrap to 0; it SHALL hold while Enable=0.
REQ-016 A tick event SHALL occur when the prescaler is at CLKS_PER_TICK-1 with Enable=1; on that edge OngoingTimer SHALL increment, and MAX_COUNT SHALL wrap to 0.
REQ-017 The tick output SHALL be 1 in exactly the cycle after a tick event, i.e. the cycle OngoingTimer shows its new value.
REQ-018 The FSM SHALL have states IDLE, ARMED, RINGING and SOLVED.
REQ-019 In IDLE or ARMED, SetAlarm=1 with AlarmIn≤MAX_COUNT SHALL load the alarm register and go to ARMED; AlarmIn>MAX_COUNT SHALL be ignored and leave state and register unchanged.
REQ-020 In RINGING or SOLVED, SetAlarm SHALL be ignored.
REQ-021 In ARMED, a tick event whose new timer value equals the pre-edge alarm register value SHALL go to RINGING on that same edge.
REQ-022 SetAlarm coincident with a trigger tick SHALL still load the new alarm value, and the trigger SHALL use the old value.
REQ-023 Arming while OngoingTimer already equals AlarmIn SHALL NOT ring until the timer next reaches that value.
REQ-024 In RINGING, startEq1 and ringing SHALL be 1.
REQ-025 In RINGING, correct=1 and turnOff=1 in the same cycle SHALL go to SOLVED; correct alone or turnOff alone SHALL be ignored.
REQ-026 The solved output SHALL pulse 1 for the first cycle in SOLVED.
REQ-027 In SOLVED, startEq1 and ringing SHALL be 0, and the next tick event SHALL return the FSM to ARMED with the same alarm value.
REQ-028 RINGING SHALL persist indefinitely until it is dismissed or reset; the timer SHALL keep counting during RINGING.
REQ-029 In IDLE and ARMED, startEq1 and ringing SHALL be 0.

Reset
REQ-030 Reset SHALL dominate all other inputs.
REQ-031 On Reset, prescaler, OngoingTimer, alarm register, tick, solved, startEq1 and ringing SHALL be 0, and the FSM SHALL be in IDLE.
REQ-032 Reset asserted mid-RINGING SHALL drop startEq1 in the following cycle.

Verification (CLKS_PER_TICK=4, MAX_COUNT=9)
REQ-033 Enable=1 for 44 cycles from reset: tick pulses every 4 cycles, and OngoingTimer runs 0..9 then wraps to 0.
REQ-034 Arm with AlarmIn=3 from timer 0: ringing=1 and startEq1=1 in the same cycle OngoingTimer=3.
REQ-035 While RINGING, drive correct=1, turnOff=0, then correct=0, turnOff=1: the block stays RINGING. Then drive both =1: solved pulses once, startEq1=0, ARMED resumes at the next tick, and the alarm rings again when the timer next reaches 3.
REQ-036 Arm with AlarmIn=12: rejected and the block stays IDLE. Arm with AlarmIn=5 while OngoingTimer=5: no ring until after the wrap.
REQ-037 Enable=0 for 10 cycles mid-count: prescaler and OngoingTimer frozen, with no tick.
REQ-038 Reset during RINGING: the cycle after, all outputs are 0 and the state is IDLE; SetAlarm is then required to re-arm.
